// File: rtl/alu_arbiter_if.sv
// Request/response bundle shared by the two ALU requesters and the arbiter.
// master: requester side (drives requests, consumes responses).
// slave : arbiter side (accepts requests, returns results).
// Ports  : req_valid/ready/a/b/ctrl per port, rsp_valid/ready per port,
//          shared rsp_data/rsp_err qualified by rsp_valid_x.
interface alu_arbiter_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CTRL_W = 4
);
  logic              req_valid_0;
  logic              req_valid_1;
  logic              req_ready_0;
  logic              req_ready_1;
  logic [DATA_W-1:0] req_a_0;
  logic [DATA_W-1:0] req_a_1;
  logic [DATA_W-1:0] req_b_0;
  logic [DATA_W-1:0] req_b_1;
  logic [CTRL_W-1:0] req_ctrl_0;
  logic [CTRL_W-1:0] req_ctrl_1;
  logic              rsp_valid_0;
  logic              rsp_valid_1;
  logic              rsp_ready_0;
  logic              rsp_ready_1;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;

  modport master (
    output req_valid_0, req_valid_1, req_a_0, req_a_1, req_b_0, req_b_1,
           req_ctrl_0, req_ctrl_1, rsp_ready_0, rsp_ready_1,
    input  req_ready_0, req_ready_1, rsp_valid_0, rsp_valid_1, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid_0, req_valid_1, req_a_0, req_a_1, req_b_0, req_b_1,
           req_ctrl_0, req_ctrl_1, rsp_ready_0, rsp_ready_1,
    output req_ready_0, req_ready_1, rsp_valid_0, rsp_valid_1, rsp_data, rsp_err
  );
endinterface

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two requesters, one op in flight.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   bus (slave)         : request/response handshakes of ports 0 and 1
//   alu_inp1/2, alu_ctrl: registered operands/control driven to the ALU
//   alu_result          : combinational result from the ALU
//   busy                : high whenever the arbiter is not IDLE
module alu_arbiter #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CTRL_W = 4,
  parameter bit          RR_EN  = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_arbiter_if.slave      bus,
  output logic [DATA_W-1:0] alu_inp1,
  output logic [DATA_W-1:0] alu_inp2,
  output logic [CTRL_W-1:0] alu_ctrl,
  input  logic [DATA_W-1:0] alu_result,
  output logic              busy
);

  // Highest legal control code (NOR); anything above is reported as an error.
  localparam logic [CTRL_W-1:0] CTRL_MAX = CTRL_W'(4'b1010);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e state_q;
  state_e state_d;
  logic   owner_q;
  logic   last_grant_q;
  logic   grant_0_c;
  logic   grant_1_c;
  logic   accept_c;
  logic   rsp_done_c;
  logic   illegal_c;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Grant, next-state and handshake decode.
  always_comb begin
    state_d    = state_q;
    grant_0_c  = 1'b0;
    grant_1_c  = 1'b0;
    accept_c   = 1'b0;
    rsp_done_c = 1'b0;
    illegal_c  = (alu_ctrl > CTRL_MAX);
    case (state_q)
      IDLE: begin
        // Port 0 wins unless port 1 also asks and round-robin says it is port 1's turn.
        grant_0_c = bus.req_valid_0 & (~bus.req_valid_1 | ~RR_EN | last_grant_q);
        grant_1_c = bus.req_valid_1 & ~grant_0_c;
        accept_c  = grant_0_c | grant_1_c;
        if (accept_c) state_d = EXEC;
      end
      EXEC: state_d = RESP;
      RESP: begin
        // Only the owner's ready completes the response.
        rsp_done_c = owner_q ? bus.rsp_ready_1 : bus.rsp_ready_0;
        if (rsp_done_c) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.req_ready_0 = grant_0_c;
  assign bus.req_ready_1 = grant_1_c;
  assign busy            = (state_q != IDLE);

  // Operand capture on accept, result capture after EXEC, response release on handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_inp1        <= '0;
      alu_inp2        <= '0;
      alu_ctrl        <= '0;
      owner_q         <= 1'b0;
      last_grant_q    <= 1'b1;
      bus.rsp_valid_0 <= 1'b0;
      bus.rsp_valid_1 <= 1'b0;
      bus.rsp_data    <= '0;
      bus.rsp_err     <= 1'b0;
    end else begin
      if (accept_c) begin
        alu_inp1     <= grant_1_c ? bus.req_a_1    : bus.req_a_0;
        alu_inp2     <= grant_1_c ? bus.req_b_1    : bus.req_b_0;
        alu_ctrl     <= grant_1_c ? bus.req_ctrl_1 : bus.req_ctrl_0;
        owner_q      <= grant_1_c;
        last_grant_q <= grant_1_c;
      end
      if (state_q == EXEC) begin
        bus.rsp_data    <= illegal_c ? '0 : alu_result;
        bus.rsp_err     <= illegal_c;
        bus.rsp_valid_0 <= ~owner_q;
        bus.rsp_valid_1 <= owner_q;
      end
      if (rsp_done_c) begin
        bus.rsp_valid_0 <= 1'b0;
        bus.rsp_valid_1 <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a round-robin instance and a fixed-priority
// instance, each fed by a behavioural ALU model.
module tb_alu_arbiter;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CTRL_W = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  alu_arbiter_if #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) bus ();
  alu_arbiter_if #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) bus_fp ();

  logic [DATA_W-1:0] inp1, inp2, res, inp1_fp, inp2_fp, res_fp;
  logic [CTRL_W-1:0] ctrl, ctrl_fp;
  logic              busy, busy_fp;

  // Reference ALU; illegal codes return junk so the arbiter's zeroing is visible.
  function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                        input logic [3:0] c);
    case (c)
      4'd0:    return a & b;
      4'd1:    return a | b;
      4'd2:    return a + b;
      4'd3:    return a << b[4:0];
      4'd4:    return a ^ b;
      4'd5:    return a - b;
      4'd6:    return {31'b0, a < b};
      4'd7:    return {31'b0, $signed(a) < $signed(b)};
      4'd8:    return a >> b[4:0];
      4'd9:    return $unsigned($signed(a) >>> b[4:0]);
      4'd10:   return ~(a | b);
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  assign res    = alu_f(inp1, inp2, ctrl);
  assign res_fp = alu_f(inp1_fp, inp2_fp, ctrl_fp);

  alu_arbiter #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .RR_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .alu_inp1(inp1), .alu_inp2(inp2), .alu_ctrl(ctrl),
    .alu_result(res), .busy(busy)
  );

  alu_arbiter #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .RR_EN(1'b0)) dut_fp (
    .clk(clk), .rst_n(rst_n), .bus(bus_fp),
    .alu_inp1(inp1_fp), .alu_inp2(inp2_fp), .alu_ctrl(ctrl_fp),
    .alu_result(res_fp), .busy(busy_fp)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic drive0(input logic v, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] c);
    bus.req_valid_0 = v; bus.req_a_0 = a; bus.req_b_0 = b; bus.req_ctrl_0 = c;
  endtask

  task automatic drive1(input logic v, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] c);
    bus.req_valid_1 = v; bus.req_a_1 = a; bus.req_b_1 = b; bus.req_ctrl_1 = c;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    bit even;
    drive0(1'b0, 0, 0, 4'd0);
    drive1(1'b0, 0, 0, 4'd0);
    bus.rsp_ready_0 = 1'b0; bus.rsp_ready_1 = 1'b0;
    bus_fp.req_valid_0 = 1'b0; bus_fp.req_valid_1 = 1'b0;
    bus_fp.req_a_0 = 1; bus_fp.req_b_0 = 1; bus_fp.req_ctrl_0 = 4'd2;
    bus_fp.req_a_1 = 8; bus_fp.req_b_1 = 1; bus_fp.req_ctrl_1 = 4'd1;
    bus_fp.rsp_ready_0 = 1'b1; bus_fp.rsp_ready_1 = 1'b1;

    // Reset values
    repeat (2) tick();
    chk("rst_busy",   32'(busy), 0);
    chk("rst_inp1",   inp1, 0);
    chk("rst_inp2",   inp2, 0);
    chk("rst_ctrl",   32'(ctrl), 0);
    chk("rst_rv0",    32'(bus.rsp_valid_0), 0);
    chk("rst_rv1",    32'(bus.rsp_valid_1), 0);
    chk("rst_data",   bus.rsp_data, 0);
    chk("rst_err",    32'(bus.rsp_err), 0);
    rst_n = 1'b1;
    tick();

    // Single ADD on port 0
    bus.rsp_ready_0 = 1'b1; bus.rsp_ready_1 = 1'b1;
    drive0(1'b1, 5, 7, 4'b0010);
    #1;
    chk("add_rdy0", 32'(bus.req_ready_0), 1);
    chk("add_rdy1", 32'(bus.req_ready_1), 0);
    tick();
    drive0(1'b0, 5, 7, 4'b0010);
    chk("add_busy_exec", 32'(busy), 1);
    chk("add_inp1", inp1, 5);
    chk("add_inp2", inp2, 7);
    chk("add_ctrl", 32'(ctrl), 2);
    chk("add_rv0_early", 32'(bus.rsp_valid_0), 0);
    tick();
    chk("add_rv0", 32'(bus.rsp_valid_0), 1);
    chk("add_rv1", 32'(bus.rsp_valid_1), 0);
    chk("add_data", bus.rsp_data, 12);
    chk("add_err", 32'(bus.rsp_err), 0);
    tick();
    chk("add_rv0_clr", 32'(bus.rsp_valid_0), 0);
    chk("add_busy_done", 32'(busy), 0);

    // Round-robin contention: grants alternate 0,1,0,1
    do_reset();
    drive0(1'b1, 10, 3, 4'b0101);
    drive1(1'b1, 32'hFF, 32'h0F, 4'b0100);
    for (int k = 0; k < 4; k++) begin
      even = (k % 2) == 0;
      #1;
      chk("rr_rdy0", 32'(bus.req_ready_0), 32'(even));
      chk("rr_rdy1", 32'(bus.req_ready_1), 32'(!even));
      tick();
      chk("rr_exec_rdy0", 32'(bus.req_ready_0), 0);
      chk("rr_exec_rdy1", 32'(bus.req_ready_1), 0);
      tick();
      chk("rr_rv0", 32'(bus.rsp_valid_0), 32'(even));
      chk("rr_rv1", 32'(bus.rsp_valid_1), 32'(!even));
      chk("rr_data", bus.rsp_data, even ? 32'd7 : 32'hF0);
      tick();
    end
    drive0(1'b0, 0, 0, 4'd0);
    drive1(1'b0, 0, 0, 4'd0);

    // Back-pressure on port 1 with port 0 pending
    do_reset();
    bus.rsp_ready_1 = 1'b0;
    drive1(1'b1, 32'hFFFF_FFFF, 1, 4'b0111);
    #1;
    chk("bp_rdy1", 32'(bus.req_ready_1), 1);
    tick();
    drive1(1'b0, 0, 0, 4'd0);
    drive0(1'b1, 32'hF0F0, 32'hFF00, 4'b0000);
    tick();
    chk("bp_rv1", 32'(bus.rsp_valid_1), 1);
    chk("bp_data", bus.rsp_data, 1);
    repeat (5) begin
      tick();
      chk("bp_hold_rv1", 32'(bus.rsp_valid_1), 1);
      chk("bp_hold_rv0", 32'(bus.rsp_valid_0), 0);
      chk("bp_hold_data", bus.rsp_data, 1);
      chk("bp_hold_rdy0", 32'(bus.req_ready_0), 0);
    end
    bus.rsp_ready_1 = 1'b1;
    tick();
    chk("bp_rv1_clr", 32'(bus.rsp_valid_1), 0);
    chk("bp_idle", 32'(busy), 0);
    chk("bp_rdy0", 32'(bus.req_ready_0), 1);
    tick();
    drive0(1'b0, 0, 0, 4'd0);
    tick();
    chk("bp_p0_rv0", 32'(bus.rsp_valid_0), 1);
    chk("bp_p0_data", bus.rsp_data, 32'hF000);
    tick();

    // Illegal control code, then a legal op
    drive0(1'b1, 3, 4, 4'b1100);
    tick();
    drive0(1'b0, 0, 0, 4'd0);
    tick();
    chk("ill_rv0", 32'(bus.rsp_valid_0), 1);
    chk("ill_data", bus.rsp_data, 0);
    chk("ill_err", 32'(bus.rsp_err), 1);
    tick();
    drive0(1'b1, 3, 4, 4'b0001);
    tick();
    drive0(1'b0, 0, 0, 4'd0);
    tick();
    chk("leg_data", bus.rsp_data, 7);
    chk("leg_err", 32'(bus.rsp_err), 0);
    tick();
    chk("hold_inp1", inp1, 3);
    chk("hold_ctrl", 32'(ctrl), 1);

    // Fixed priority: port 0 always wins
    bus_fp.req_valid_0 = 1'b1; bus_fp.req_valid_1 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("fp_rdy0", 32'(bus_fp.req_ready_0), 1);
      chk("fp_rdy1", 32'(bus_fp.req_ready_1), 0);
      tick();
      tick();
      chk("fp_rv0", 32'(bus_fp.rsp_valid_0), 1);
      chk("fp_rv1", 32'(bus_fp.rsp_valid_1), 0);
      chk("fp_data", bus_fp.rsp_data, 2);
      tick();
    end
    bus_fp.req_valid_0 = 1'b0; bus_fp.req_valid_1 = 1'b0;

    // Reset during EXEC drops the op
    do_reset();
    drive1(1'b1, 100, 23, 4'b0010);
    #1;
    chk("rx_rdy1", 32'(bus.req_ready_1), 1);
    tick();
    drive1(1'b0, 0, 0, 4'd0);
    chk("rx_busy", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("rx_busy_rst", 32'(busy), 0);
    chk("rx_inp1_rst", inp1, 0);
    chk("rx_ctrl_rst", 32'(ctrl), 0);
    chk("rx_rv1_rst", 32'(bus.rsp_valid_1), 0);
    chk("rx_data_rst", bus.rsp_data, 0);
    tick();
    rst_n = 1'b1;
    repeat (3) begin
      tick();
      chk("rx_no_rv1", 32'(bus.rsp_valid_1), 0);
      chk("rx_no_busy", 32'(busy), 0);
    end
    drive0(1'b1, 2, 2, 4'b0010);
    drive1(1'b1, 9, 4, 4'b0101);
    #1;
    chk("rx_rdy0", 32'(bus.req_ready_0), 1);
    chk("rx_rdy1", 32'(bus.req_ready_1), 0);
    tick();
    drive0(1'b0, 0, 0, 4'd0);
    drive1(1'b0, 0, 0, 4'd0);
    tick();
    chk("rx_rv0", 32'(bus.rsp_valid_0), 1);
    chk("rx_data", bus.rsp_data, 4);
    tick();
    chk("rx_done", 32'(busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one combinational ALU instance between two requesters, e.g. the execute stage (port 0) and an address/branch helper (port 1).
- Arbitrates between them, registers the selected operands and control code onto the ALU inputs, and captures the ALU result.
- Returns the result to the granting requester over a valid/ready response handshake.
- Exactly one operation is in flight at a time.

Parameters:
- DATA_W, 32, operand/result width; must match the ALU.
- CTRL_W, 4, ALU control code width.
- RR_EN, 1, 1 = round-robin arbitration; 0 = fixed priority with port 0 winning.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid_0 / req_valid_1  input  1  request present on port 0 / 1.
- req_ready_0 / req_ready_1  output  1  request accepted this cycle.
- req_a_0 / req_a_1  input  DATA_W  operand 1.
- req_b_0 / req_b_1  input  DATA_W  operand 2.
- req_ctrl_0 / req_ctrl_1  input  CTRL_W  ALU control code.
- rsp_valid_0 / rsp_valid_1  output  1  result available for port 0 / 1.
- rsp_ready_0 / rsp_ready_1  input  1  port consumes the result.
- rsp_data  output  DATA_W  result; shared by both ports and qualified by rsp_valid_x.
- rsp_err  output  1  control code was illegal (4'b1011..4'b1111); rsp_data = 0 in that case.
- alu_inp1, alu_inp2  output  DATA_W  to ALU inp1/inp2.
- alu_ctrl  output  CTRL_W  to ALU alu_ctrl.
- alu_result  input  DATA_W  from ALU result (combinational).
- busy  output  1  state != IDLE.

Behaviour:
- Clocking and reset: single clock. rst_n is asynchronous and active-low.
- Reset values:
  - state = IDLE.
  - alu_inp1 = alu_inp2 = 0; alu_ctrl = 0.
  - rsp_valid_0/1 = 0; rsp_data = 0; rsp_err = 0.
  - last_grant = 1, so port 0 wins the first contention.
- Reset mid-operation drops any in-flight op; no response is issued.
- States:
  - IDLE: ready to accept a request.
  - EXEC: operands held on the ALU for one cycle.
  - RESP: result held for the requester.
- Grant (combinational, IDLE only):
  - Only one valid: that port wins.
  - Both valid with RR_EN=1: the port != last_grant wins.
  - Both valid with RR_EN=0: port 0 wins.
- req_ready_x = (state==IDLE) & grant_x. It may depend combinationally on req_valid_x. It is 0 in EXEC and RESP.
- Requesters hold valid, operands and ctrl stable until ready. Dropping valid before ready is a protocol error and is not checked.
- Accept (IDLE, valid&ready at edge E0):
  - Register a, b, ctrl onto alu_inp1/alu_inp2/alu_ctrl.
  - Record owner id; last_grant <= owner.
  - state -> EXEC.
- EXEC (one cycle), at edge E1:
  - rsp_data <= alu_result.
  - rsp_err <= (ctrl > 4'b1010).
  - rsp_valid_owner <= 1; state -> RESP.
- RESP:
  - rsp_valid_owner, rsp_data and rsp_err are held until rsp_ready_owner = 1.
  - On that edge, rsp_valid clears and state -> IDLE.
  - rsp_ready of the non-owner port is ignored.
- Latency: the response is visible in the cycle after E1, two cycles after accept. Minimum issue interval is 3 cycles, since the next accept happens in the IDLE cycle after the response handshake.
- alu_* outputs keep their last registered values between operations.
- The ALU is purely combinational, so the arbiter adds no ALU-specific timing. Its supported codes are:
  - 0000 AND, 0001 OR, 0010 ADD, 0011 SLL.
  - 0100 XOR, 0101 SUB, 0110 SLTU, 0111 SLT.
  - 1000 SRL, 1001 SRA, 1010 NOR.
- Never both rsp_valid_0 and rsp_valid_1 high at once.

Test Plan:
- Single ADD on port 0: a=5, b=7, ctrl=0010, rsp_ready=1 -> req_ready_0 high in the accept cycle; rsp_valid_0 two cycles later with rsp_data=12, rsp_err=0; busy drops after the handshake.
- Contention, RR_EN=1, both valid every cycle with SUB 10-3 (port 0) and XOR FF^0F (port 1) -> grants alternate 0,1,0,1; port 0 sees 7 and port 1 sees F0; rsp_valid_1 never high on a port 0 op.
- Back-pressure: port 1 SLT a=FFFFFFFF, b=1, rsp_ready_1=0 for 5 cycles -> rsp_valid_1 held with rsp_data=1 stable; a pending port 0 request stays un-ready until the handshake.
- Illegal code 1100 on port 0 -> rsp_data=0, rsp_err=1; the next legal op returns rsp_err=0.
- RR_EN=0 with both valid continuously -> port 0 always granted, port 1 starved.
- rst_n pulsed low during EXEC -> all outputs reset immediately; no rsp_valid follows; the next request completes normally with port 0 priority.
